// File: rtl/m_007_seg_scan_mux_pkg.sv
// m_007_pkg: shared widths, anode level and BCD digit type for the scan mux.
package m_007_pkg;
  localparam int BCD_W = 4;
  localparam logic AN_OFF = 1'b1;
  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/m_007_seg_scan_mux_if.sv
// m_007_seg_scan_mux_if: valid/ready digit-set handshake into the scan mux.
interface m_007_seg_scan_mux_if #(parameter int NUM_DIGITS = 4);
  import m_007_pkg::*;
  logic [BCD_W*NUM_DIGITS-1:0] digits_i;
  logic digits_valid_i;
  logic digits_ready_o;
  modport master(output digits_i, digits_valid_i, input digits_ready_o);
  modport slave(input digits_i, digits_valid_i, output digits_ready_o);
endinterface

// File: rtl/m_007_tick_gen.sv
// m_007_tick_gen: free-running prescaler, tick_o high while the count is CLK_DIV-1.
module m_007_tick_gen #(parameter int CLK_DIV = 100000) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == CW'(CLK_DIV - 1);
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/m_007_seg_scan_mux.sv
// m_007_seg_scan_mux: tear-free multi-digit 7-segment scan driver.
// Define M_007_LZB_EN to blank leading zero digits.
module m_007_seg_scan_mux import m_007_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  m_007_seg_scan_mux_if.slave dig_if,
  input  logic enable_i,
  output bcd_t bcd_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic frame_o
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic tick, frame_ev, xfer, apply;
  logic [IW-1:0] idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0] disp_q, disp_d, pdata_q, pdata_d;
  logic pend_q, pend_d, ready_q, ready_d, frame_q;
  bcd_t bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, lit;
  logic seen;
  m_007_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk_i(clk_i), .rst_ni(rst_ni), .tick_o(tick));
  // Outputs are registered from next-state values so they move on the same edge as the index.
  always_comb begin
    frame_ev = tick && idx_q == IW'(NUM_DIGITS - 1);
    xfer = dig_if.digits_valid_i && ready_q;
    apply = frame_ev && pend_q;
    idx_d = tick ? (frame_ev ? '0 : idx_q + 1'b1) : idx_q;
    disp_d = apply ? pdata_q : disp_q;
    pdata_d = xfer ? dig_if.digits_i : pdata_q;
    pend_d = xfer || (pend_q && !apply);
    ready_d = !pend_d;
    bcd_d = disp_d[idx_d];
    seen = 1'b0;
`ifdef M_007_LZB_EN
    lit = '0;
    lit[0] = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen = seen || disp_d[i] != '0;
      lit[i] = seen;
    end
`else
    lit = '1;
`endif
    an_d = enable_i ? ~(lit & (NUM_DIGITS'(1) << idx_d)) : {NUM_DIGITS{AN_OFF}};
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      idx_q <= '0;
      disp_q <= '0;
      pdata_q <= '0;
      pend_q <= 1'b0;
      ready_q <= 1'b1;
      bcd_q <= '0;
      an_q <= {NUM_DIGITS{AN_OFF}};
      frame_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      disp_q <= disp_d;
      pdata_q <= pdata_d;
      pend_q <= pend_d;
      ready_q <= ready_d;
      bcd_q <= bcd_d;
      an_q <= an_d;
      frame_q <= frame_ev;
    end
  assign dig_if.digits_ready_o = ready_q;
  assign bcd_o = bcd_q;
  assign an_o = an_q;
  assign digit_idx_o = idx_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_m_007_seg_scan_mux.sv
// tb_m_007_seg_scan_mux: randomized scenarios checked against a time-based reference model.
module tb_m_007_seg_scan_mux;
  localparam int N = 4, DIV = 4, FRAME = N * DIV;
  logic clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b1;
  logic [3:0] bcd_o, an_o;
  logic [1:0] digit_idx_o;
  logic frame_o;
  int vecs = 0, errs = 0;
  m_007_seg_scan_mux_if #(.NUM_DIGITS(N)) dif();
  m_007_seg_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dig_if(dif), .enable_i(enable_i),
    .bcd_o(bcd_o), .an_o(an_o), .digit_idx_o(digit_idx_o), .frame_o(frame_o));
  always #5 clk_i = ~clk_i;
  // Model: slot and frame position follow purely from edges elapsed since reset.
  int t;
  logic [15:0] m_disp, m_pdata;
  logic m_pend, m_en;
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      t <= 0; m_disp <= '0; m_pdata <= '0; m_pend <= 1'b0; m_en <= 1'b0;
    end else begin
      t <= t + 1;
      m_en <= enable_i;
      if ((t + 1) % FRAME == 0 && m_pend) begin m_disp <= m_pdata; m_pend <= 1'b0; end
      if (dif.digits_valid_i && !m_pend) begin m_pdata <= dif.digits_i; m_pend <= 1'b1; end
    end
  function automatic logic [11:0] expv();
    int idx = (t / DIV) % N;
    logic [3:0] an = 4'hF;
`ifdef M_007_LZB_EN
    int hi = 0;
    for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) hi = i;
    if (m_en && idx <= hi) an[idx] = 1'b0;
`else
    if (m_en) an[idx] = 1'b0;
`endif
    return {m_disp[4*idx +: 4], an, 2'(idx), 1'(t > 0 && t % FRAME == 0), !m_pend};
  endfunction
  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    vecs++;
    if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== 12'h0F1) begin
      errs++; $display("FAIL reset_state act=%h exp=%h", {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, 12'h0F1);
    end
    rst_ni = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL reset_scan t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
      if (i == 4) begin
        vecs++;
        if ({digit_idx_o, an_o} !== {2'd1, 4'b1101}) begin
          errs++; $display("FAIL first_tick act=%h exp=%h", {digit_idx_o, an_o}, {2'd1, 4'b1101});
        end
      end
    end
  endtask
  task automatic test_handshake;
    int i;
    for (i = 0; i < 64 && !((t / DIV) % N == 1 && dif.digits_ready_o); i++) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL hs_wait t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
    end
    dif.digits_i = 16'h4321; dif.digits_valid_i = 1'b1;
    @(negedge clk_i);
    dif.digits_valid_i = 1'b0;
    vecs++;
    if (dif.digits_ready_o !== 1'b0) begin errs++; $display("FAIL hs_ready_low act=%b exp=0", dif.digits_ready_o); end
    for (i = 0; i < 64 && !(frame_o && dif.digits_ready_o); i++) begin
      vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL hs_hold t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
      @(negedge clk_i);
    end
    vecs++;
    if (i == 64) begin errs++; $display("FAIL hs_timeout act=no_frame exp=frame"); end
    for (int s = 0; s < N; s++) begin
      vecs++;
      if ({bcd_o, an_o, dif.digits_ready_o} !== {4'(s + 1), ~(4'b0001 << s), 1'b1}) begin
        errs++; $display("FAIL hs_slot%0d act=%h exp=%h", s, {bcd_o, an_o, dif.digits_ready_o}, {4'(s + 1), ~(4'b0001 << s), 1'b1});
      end
      repeat (DIV) @(negedge clk_i);
    end
  endtask
  task automatic test_back_to_back;
    int n = 0;
    for (int i = 0; i < 64 && !dif.digits_ready_o; i++) @(negedge clk_i);
    dif.digits_i = 16'h8765; dif.digits_valid_i = 1'b1;
    @(negedge clk_i);
    dif.digits_i = 16'h9999;
    for (int i = 0; i < 64 && dif.digits_valid_i; i++) begin
      if (dif.digits_ready_o) n++;
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL bp t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
      if (n > 0) dif.digits_valid_i = 1'b0;
    end
    dif.digits_valid_i = 1'b0;
    vecs++;
    if (n !== 1) begin errs++; $display("FAIL bp_count act=%0d exp=1", n); end
    repeat (2 * FRAME) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL bp_after t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
    end
    vecs++;
    if (m_disp !== 16'h9999) begin errs++; $display("FAIL bp_final act=%h exp=9999", m_disp); end
  endtask
  task automatic test_coincident;
    logic [15:0] old_d = m_disp, new_d;
    int i;
    new_d = {12'($urandom), 4'(old_d[3:0] + 4'd1)};
    for (i = 0; i < 64 && !(dif.digits_ready_o && (t + 1) % FRAME == 0); i++) @(negedge clk_i);
    vecs++;
    if (i == 64) begin errs++; $display("FAIL coin_timeout act=no_slot exp=slot"); end
    dif.digits_i = new_d; dif.digits_valid_i = 1'b1;
    @(negedge clk_i);
    dif.digits_valid_i = 1'b0;
    vecs++;
    if ({frame_o, bcd_o} !== {1'b1, old_d[3:0]}) begin
      errs++; $display("FAIL coin_now act=%h exp=%h", {frame_o, bcd_o}, {1'b1, old_d[3:0]});
    end
    repeat (FRAME) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL coin t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
    end
    vecs++;
    if ({frame_o, bcd_o} !== {1'b1, new_d[3:0]}) begin
      errs++; $display("FAIL coin_next act=%h exp=%h", {frame_o, bcd_o}, {1'b1, new_d[3:0]});
    end
  endtask
  task automatic test_enable;
    int frames = 0, want = 0;
    for (int i = 0; i < 16 && t % DIV != 1; i++) @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i); vecs++;
    if (an_o !== 4'hF) begin errs++; $display("FAIL en_off act=%h exp=f", an_o); end
    repeat (3 * FRAME) begin
      @(negedge clk_i); vecs++;
      if (frame_o) frames++;
      if (t % FRAME == 0) want++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL en t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
    end
    vecs++;
    if (frames !== want || frames < 2) begin errs++; $display("FAIL en_frames act=%0d exp=%0d", frames, want); end
    enable_i = 1'b1;
    @(negedge clk_i); vecs++;
    if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
      errs++; $display("FAIL en_restore act=%h exp=%h", {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
    end
  endtask
  task automatic test_random;
    repeat (400) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL rand t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
      dif.digits_valid_i = $urandom_range(0, 3) == 0;
      dif.digits_i = ($urandom_range(0, 1) == 0) ? 16'($urandom) & 16'h0FF0 : 16'($urandom);
      enable_i = $urandom_range(0, 7) != 0;
    end
    dif.digits_valid_i = 1'b0;
    enable_i = 1'b1;
  endtask
`ifdef M_007_LZB_EN
  task automatic test_lzb;
    logic [15:0] pat [2] = '{16'h0050, 16'h0000};
    logic [3:0] tab [2][4] = '{'{4'hE, 4'hD, 4'hF, 4'hF}, '{4'hE, 4'hF, 4'hF, 4'hF}};
    for (int p = 0; p < 2; p++) begin
      int i;
      for (i = 0; i < 64 && !dif.digits_ready_o; i++) @(negedge clk_i);
      dif.digits_i = pat[p]; dif.digits_valid_i = 1'b1;
      @(negedge clk_i);
      dif.digits_valid_i = 1'b0;
      for (i = 0; i < 64 && !(frame_o && dif.digits_ready_o); i++) @(negedge clk_i);
      vecs++;
      if (i == 64) begin errs++; $display("FAIL lzb_timeout act=no_frame exp=frame"); end
      for (int s = 0; s < N; s++) begin
        vecs++;
        if (an_o !== tab[p][s]) begin errs++; $display("FAIL lzb p%0d slot%0d act=%h exp=%h", p, s, an_o, tab[p][s]); end
        repeat (DIV) @(negedge clk_i);
      end
    end
  endtask
`endif
  task automatic test_async_reset;
    dif.digits_i = 16'h5a5a; dif.digits_valid_i = 1'b1;
    @(negedge clk_i);
    dif.digits_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 vecs++;
    if ({an_o, bcd_o, dif.digits_ready_o, frame_o} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL async_reset act=%h exp=%h", {an_o, bcd_o, dif.digits_ready_o, frame_o}, {4'hF, 4'h0, 1'b1, 1'b0});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2 * FRAME) begin
      @(negedge clk_i); vecs++;
      if ({bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o} !== expv()) begin
        errs++; $display("FAIL post_reset t=%0d act=%h exp=%h", t, {bcd_o, an_o, digit_idx_o, frame_o, dif.digits_ready_o}, expv());
      end
    end
  endtask
  initial begin
    dif.digits_i = '0;
    dif.digits_valid_i = 1'b0;
    test_reset;
    test_handshake;
    test_back_to_back;
    test_coincident;
    test_enable;
    test_random;
`ifdef M_007_LZB_EN
    test_lzb;
`endif
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/m_007_seg_scan_mux.md
Name: m_007_seg_scan_mux

Overview:
Time-multiplexed scan driver for a multi-digit common-anode 7-segment display. It sits directly upstream of the BCD to 7-segment decoder.
- Holds NUM_DIGITS BCD digits in a display register.
- Cycles through the digits at a divided refresh rate, presenting one digit's code on bcd_o to the decoder.
- Drives the matching active-low anode enable.
- New digit sets arrive over a valid/ready handshake and take effect only at a frame boundary, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2)
CLK_DIV, 100000, clk_i cycles per digit slot (>=2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; asynchronous, active-low
digits_i  input  4*NUM_DIGITS  BCD digits, digit 0 in [3:0] (least significant)
digits_valid_i  input  1  digits_i valid
digits_ready_o  output  1  block can accept digits_i
enable_i  input  1  1 = scan normally, 0 = all anodes off
bcd_o  output  4  BCD code of the active digit, to the decoder
an_o  output  NUM_DIGITS  anode enables, active-low, one-hot-low when lit
digit_idx_o  output  $clog2(NUM_DIGITS)  index of the active digit
frame_o  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Reset values (asynchronous): prescaler 0, index 0, display register all 4'h0, pending flag 0, digits_ready_o 1, bcd_o 4'h0, an_o all 1s, digit_idx_o 0, frame_o 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick is asserted in the cycle the count equals CLK_DIV-1.
  - Free-runs regardless of enable_i.
- Index:
  - Increments on tick and wraps NUM_DIGITS-1 -> 0.
  - The wrap raises an internal frame event.
- Handshake:
  - Transfer occurs when digits_valid_i && digits_ready_o at a rising edge.
  - digits_i is captured into a pending register, the pending flag is set, and digits_ready_o drops the next cycle.
- Frame apply:
  - On a frame event with pending set, pending is copied into the display register, pending clears, and digits_ready_o rises the next cycle.
  - If a transfer and a frame event coincide in the same cycle (only possible when ready=1), the captured data is applied at the following frame, not the current one.
- Outputs (all registered, updated the cycle after tick):
  - bcd_o = display[index].
  - digit_idx_o = index.
  - an_o = ~(1<<index) when enable_i = 1, else all 1s.
  - frame_o pulses for one cycle, aligned with the output update for index 0.
- enable_i:
  - Sampled every cycle; deassertion forces an_o to all 1s on the next edge, without waiting for tick.
  - Scanning and the handshake continue while disabled.
- BCD codes 10..15 pass through unchanged; the decoder renders them as hyphen.
- Reset mid-frame discards pending data and the display contents.

Optional Feature:
- Macro: M_007_LZB_EN (leading-zero blanking).
- Defined: any digit above the most significant nonzero display digit has its anode held high during its slot; digit 0 is always lit, so all-zero shows a single "0". Values >9 count as nonzero.
- Undefined: every digit is lit in its slot.
- Slot timing, index and frame_o are unaffected either way.

Decomposition:
- Package m_007_pkg holds:
  - BCD_W = 4
  - AN_OFF (anode inactive level = 1'b1)
  - typedef bcd_t (logic [3:0])
- One sub-module, m_007_tick_gen: parameterised prescaler producing the one-cycle tick.

Test Plan:
- Defaults overridden to NUM_DIGITS=4, CLK_DIV=4.
- Reset: hold rst_ni low mid-count -> an_o=4'b1111, bcd_o=0, digits_ready_o=1 immediately (async); after release, first tick at cycle 4, outputs at cycle 5 show index 1, an_o=4'b1101.
- Handshake/tear-free: send digits 16'h4321 at index 1 -> ready low next cycle; display keeps 0000 until the frame wrap; after wrap, slots show bcd_o 1,2,3,4 with an_o 1110,1101,1011,0111; ready returns high.
- Back-pressure: hold valid with 16'h9999 while ready=0 -> no capture until ready=1; exactly one transfer occurs.
- Coincident transfer and frame: valid at the frame-event cycle -> data appears one frame later, not this frame.
- enable_i=0 mid-slot: an_o=1111 next cycle, while frame_o continues pulsing every 16 cycles; re-enable restores the correct anode.
- M_007_LZB_EN defined, digits 16'h0050: an_o is 1111 in slots 3 and 2, lit in slots 1 and 0; digits 16'h0000 -> only digit 0 lit.
